// File: rtl/snn_result_tx_packer.sv
// snn_result_tx_packer
// Reads the output-layer spike counts after an image has been processed,
// picks the winning class, and streams a fixed-length result packet
// (header, seq, counts MSB-first, class, XOR checksum) to the UDP TX engine
// over a valid/ready byte handshake.
module snn_result_tx_packer #(
  parameter int          OUT_NEURON = 10,
  parameter int          CNT_W      = 16,
  parameter int          ADDR_W     = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              tx_start,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_rd,
  input  logic [CNT_W-1:0]  res_rdata,
  output logic [15:0]       tx_byte_num,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        win_class,
  output logic [7:0]        drop_cnt
);

  localparam int PKT_LEN = 2*OUT_NEURON + 4;
  localparam int IDX_W   = $clog2(PKT_LEN);
  localparam int FC_W    = $clog2(OUT_NEURON + 1);
  localparam int CI_W    = $clog2(OUT_NEURON);

  localparam logic [FC_W-1:0]  LAST_F   = FC_W'(OUT_NEURON);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] WIN_IDX  = IDX_W'(PKT_LEN - 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q [OUT_NEURON];
  logic [CNT_W-1:0]   cnt_d [OUT_NEURON];
  logic [CNT_W-1:0]   best_val_q, best_val_d;
  logic [CI_W-1:0]    best_idx_q, best_idx_d;
  logic [7:0]         win_class_q, win_class_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         chk_q, chk_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               tx_req_q, tx_req_d;

  logic [CI_W-1:0]    cap_idx;
  logic [CI_W-1:0]    cur_best;
  logic [IDX_W-1:0]   off;
  logic [CI_W-1:0]    nidx;
  logic [7:0]         byte_sel;

  // Packet byte selection for the current index; every source is a register,
  // so the byte holds steady while the engine stalls.
  always_comb begin
    off      = idx_q - IDX_W'(2);
    nidx     = CI_W'(off >> 1);
    byte_sel = 8'h00;
    if (idx_q == '0)
      byte_sel = HEADER;
    else if (idx_q == IDX_W'(1))
      byte_sel = seq_q;
    else if (idx_q == WIN_IDX)
      byte_sel = win_class_q;
    else if (idx_q == LAST_IDX)
      byte_sel = chk_q;
    else if (off[0])
      byte_sel = cnt_q[nidx][7:0];
    else
      byte_sel = cnt_q[nidx][15:8];
  end

  // Next-state logic, result-memory fetch, argmax and handshake bookkeeping.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    win_class_d = win_class_q;
    seq_d       = seq_q;
    chk_d       = chk_q;
    drop_cnt_d  = drop_cnt_q;
    tx_req_d    = 1'b0;
    res_rd      = 1'b0;
    res_addr    = '0;
    cap_idx     = CI_W'(fcnt_q - FC_W'(1));
    cur_best    = best_idx_q;

    // A start request arriving while a packet is in progress is only counted.
    if (tx_start && (state_q != S_IDLE) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d    = S_FETCH;
          fcnt_d     = '0;
          best_val_d = '0;
          best_idx_d = '0;
        end
      end
      S_FETCH: begin
        fcnt_d = fcnt_q + FC_W'(1);
        if (fcnt_q < LAST_F) begin
          res_rd   = 1'b1;
          res_addr = ADDR_W'(fcnt_q);
        end
        // Read data lags the address by one cycle; strict > keeps the lowest
        // index on ties and class 0 when everything is zero.
        if (fcnt_q != '0) begin
          cnt_d[cap_idx] = res_rdata;
          if (res_rdata > best_val_q) begin
            best_val_d = res_rdata;
            best_idx_d = cap_idx;
            cur_best   = cap_idx;
          end
        end
        if (fcnt_q == LAST_F) begin
          win_class_d = 8'(cur_best);
          tx_req_d    = 1'b1;
          idx_d       = '0;
          chk_d       = 8'h00;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          chk_d = chk_q ^ byte_sel;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        seq_d   = seq_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      idx_q       <= '0;
      for (int i = 0; i < OUT_NEURON; i++) cnt_q[i] <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      win_class_q <= 8'h00;
      seq_q       <= 8'h00;
      chk_q       <= 8'h00;
      drop_cnt_q  <= 8'h00;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      win_class_q <= win_class_d;
      seq_q       <= seq_d;
      chk_q       <= chk_d;
      drop_cnt_q  <= drop_cnt_d;
      tx_req_q    <= tx_req_d;
    end
  end

  assign tx_byte_num = 16'(PKT_LEN);
  assign tx_req      = tx_req_q;
  assign tx_valid    = (state_q == S_SEND);
  assign tx_data     = tx_valid ? byte_sel : 8'h00;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign win_class   = win_class_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_snn_result_tx_packer.sv
// Directed bench for snn_result_tx_packer: fixed count tables with
// hand-worked packet bytes, backpressure, dropped starts, seq wrap and reset.
module tb_snn_result_tx_packer;

  localparam int N   = 10;
  localparam int PKT = 24;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        tx_start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [15:0] res_rdata = 16'h0;
  logic [3:0]  res_addr;
  logic        res_rd;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [7:0]  win_class;
  logic [7:0]  drop_cnt;

  snn_result_tx_packer dut (
    .CLK(CLK), .RST_N(RST_N), .tx_start(tx_start),
    .res_addr(res_addr), .res_rd(res_rd), .res_rdata(res_rdata),
    .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .win_class(win_class), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  // Result memory: one-cycle read latency.
  logic [15:0] mem [16];
  always @(posedge CLK) if (res_rd) res_rdata <= mem[res_addr];

  // Hand-worked packet for counts {3,0,7,1,0,0,2,0,0,5} at seq 0:
  // winner 2, checksum A5^03^07^01^02^05^02 = A5.
  localparam logic [7:0] BASIC [PKT] = '{
    8'hA5, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h01,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h05, 8'h02, 8'hA5};
  localparam logic [15:0] BASIC_CNT [N] = '{16'd3, 16'd0, 16'd7, 16'd1, 16'd0,
                                            16'd0, 16'd2, 16'd0, 16'd0, 16'd5};

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  got [$];
  int          done_cnt, req_cnt, first_lat, stall_bad;
  logic        busy_after, timeout;
  logic [15:0] req_bytenum;

  task automatic load_basic();
    for (int i = 0; i < 16; i++) mem[i] = (i < N) ? BASIC_CNT[i] : 16'h0;
  endtask

  // Sends one start pulse and records accepted bytes until done (or abort).
  task automatic do_packet(input int pct, input int drops, input int abort_at);
    int          left;
    logic        r, stalled, saw_done;
    logic [7:0]  prev;
    left = drops; stalled = 1'b0; saw_done = 1'b0; prev = 8'h00;
    got.delete(); done_cnt = 0; req_cnt = 0; first_lat = -1; stall_bad = 0;
    busy_after = 1'bx; timeout = 1'b1; req_bytenum = 16'h0;
    @(negedge CLK); tx_start = 1'b1;
    @(negedge CLK); tx_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (saw_done) begin busy_after = busy; timeout = 1'b0; break; end
      if (abort_at > 0 && got.size() == abort_at) begin timeout = 1'b0; break; end
      if (done) begin done_cnt++; saw_done = 1'b1; end
      if (tx_req) begin req_cnt++; req_bytenum = tx_byte_num; end
      if (stalled && tx_data !== prev) stall_bad++;
      r = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      tx_ready = r;
      if (tx_valid && r) begin
        if (got.size() == 0) first_lat = cyc + 1;
        got.push_back(tx_data);
      end
      stalled = tx_valid && !r;
      prev = tx_data;
      if (left > 0 && tx_valid) begin tx_start = 1'b1; left--; end
      else tx_start = 1'b0;
      @(negedge CLK);
    end
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if ({busy, done, tx_valid, tx_req, res_rd} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, tx_valid, tx_req, res_rd}); end
    checks++; if ({tx_data, win_class, drop_cnt} !== 24'h0) begin errors++;
      $display("FAIL reset_data got %h want 000000", {tx_data, win_class, drop_cnt}); end
    checks++; if (res_addr !== 4'h0) begin errors++;
      $display("FAIL reset_addr got %h want 0", res_addr); end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if ({busy, tx_valid} !== 2'b0) begin errors++;
      $display("FAIL idle_after_reset got %b want 00", {busy, tx_valid}); end
  endtask

  task automatic test_basic();
    load_basic();
    do_packet(100, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    checks++; if (got.size() != PKT) begin errors++;
      $display("FAIL basic_len got %0d want %0d", got.size(), PKT); end
    for (int i = 0; i < PKT && i < got.size(); i++) begin
      checks++; if (got[i] !== BASIC[i]) begin errors++;
        $display("FAIL basic_byte%0d got %h want %h", i, got[i], BASIC[i]); end
    end
    checks++; if (win_class !== 8'd2) begin errors++;
      $display("FAIL basic_win got %0d want 2", win_class); end
    checks++; if (done_cnt != 1) begin errors++;
      $display("FAIL basic_done got %0d want 1", done_cnt); end
    checks++; if (busy_after !== 1'b0) begin errors++;
      $display("FAIL basic_busy_after got %b want 0", busy_after); end
    checks++; if (req_cnt != 1) begin errors++;
      $display("FAIL basic_req got %0d want 1", req_cnt); end
    checks++; if (req_bytenum !== 16'd24) begin errors++;
      $display("FAIL basic_bytenum got %0d want 24", req_bytenum); end
    checks++; if (first_lat < 1 || first_lat > N + 3) begin errors++;
      $display("FAIL basic_latency got %0d want <= %0d", first_lat, N + 3); end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[4] = 16'h0123; mem[8] = 16'h0123;
    do_packet(100, 0, 0);
    checks++; if (got.size() != PKT) begin errors++;
      $display("FAIL tie_len got %0d want %0d", got.size(), PKT); end
    else begin
      checks++; if ({got[10], got[11], got[18], got[19]} !== 32'h0123_0123) begin errors++;
        $display("FAIL tie_bytes got %h%h%h%h want 01230123", got[10], got[11], got[18], got[19]); end
      checks++; if (got[1] !== 8'h01) begin errors++;
        $display("FAIL tie_seq got %h want 01", got[1]); end
      checks++; if (got[22] !== 8'h04) begin errors++;
        $display("FAIL tie_winbyte got %h want 04", got[22]); end
      checks++; if (got[23] !== 8'hA0) begin errors++;
        $display("FAIL tie_chk got %h want a0", got[23]); end
    end
    checks++; if (win_class !== 8'd4) begin errors++;
      $display("FAIL tie_win got %0d want 4", win_class); end
  endtask

  task automatic test_zero();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    do_packet(100, 0, 0);
    checks++; if (win_class !== 8'd0) begin errors++;
      $display("FAIL zero_win got %0d want 0", win_class); end
    checks++; if (got.size() != PKT) begin errors++;
      $display("FAIL zero_len got %0d want %0d", got.size(), PKT); end
    else begin
      checks++; if (got[23] !== (8'hA5 ^ 8'h02)) begin errors++;
        $display("FAIL zero_chk got %h want a7", got[23]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    load_basic();
    do_packet(30, 0, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++; if (got.size() != PKT) begin errors++;
      $display("FAIL bp_len got %0d want %0d", got.size(), PKT); end
    for (int i = 0; i < PKT && i < got.size(); i++) begin
      e = (i == 1) ? 8'h03 : (i == 23) ? (8'hA5 ^ 8'h03) : BASIC[i];
      checks++; if (got[i] !== e) begin errors++;
        $display("FAIL bp_byte%0d got %h want %h", i, got[i], e); end
    end
    checks++; if (stall_bad != 0) begin errors++;
      $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad); end
  endtask

  task automatic test_drop();
    int bad;
    load_basic();
    do_packet(100, 3, 0);
    checks++; if (drop_cnt !== 8'd3) begin errors++;
      $display("FAIL drop_3 got %0d want 3", drop_cnt); end
    bad = 0;
    for (int i = 0; i < PKT; i++)
      if (i >= got.size() || got[i] !== ((i == 1) ? 8'h04 : (i == 23) ? (8'hA5 ^ 8'h04) : BASIC[i])) bad++;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL drop_packet got %0d bad bytes want 0", bad); end
    for (int p = 0; p < 10; p++) do_packet(100, 24, 0);
    checks++; if (drop_cnt !== 8'd243) begin errors++;
      $display("FAIL drop_243 got %0d want 243", drop_cnt); end
    for (int p = 0; p < 3; p++) do_packet(100, 24, 0);
    checks++; if (drop_cnt !== 8'd255) begin errors++;
      $display("FAIL drop_sat got %0d want 255", drop_cnt); end
    checks++; if (got.size() != PKT || got[1] !== 8'd17) begin errors++;
      $display("FAIL drop_seq got %0d want 17", (got.size() > 1) ? got[1] : 8'hxx); end
  endtask

  task automatic test_reset_mid();
    load_basic();
    do_packet(100, 0, 10);
    checks++; if (tx_valid !== 1'b1) begin errors++;
      $display("FAIL mid_in_send got %b want 1", tx_valid); end
    RST_N = 1'b0;
    #1;
    checks++; if ({tx_valid, busy, tx_req} !== 3'b0) begin errors++;
      $display("FAIL mid_async got %b want 000", {tx_valid, busy, tx_req}); end
    checks++; if (drop_cnt !== 8'd0) begin errors++;
      $display("FAIL mid_drop_clr got %0d want 0", drop_cnt); end
    tx_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if ({tx_valid, busy, done} !== 3'b0) begin errors++;
      $display("FAIL mid_no_resume got %b want 000", {tx_valid, busy, done}); end
    do_packet(100, 0, 0);
    checks++; if (got.size() != PKT) begin errors++;
      $display("FAIL mid_next_len got %0d want %0d", got.size(), PKT); end
    for (int i = 0; i < PKT && i < got.size(); i++) begin
      checks++; if (got[i] !== BASIC[i]) begin errors++;
        $display("FAIL mid_next_byte%0d got %h want %h", i, got[i], BASIC[i]); end
    end
  endtask

  task automatic test_wrap();
    int         bad;
    logic [7:0] s;
    load_basic();
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    for (int p = 0; p < 257; p++) begin
      s = 8'(p);
      do_packet(100, 0, 0);
      checks++; if (got.size() < 2 || got[1] !== s) begin errors++;
        $display("FAIL wrap_seq%0d got %h want %h", p, (got.size() > 1) ? got[1] : 8'hxx, s); end
      bad = 0;
      for (int i = 0; i < PKT; i++)
        if (i >= got.size() || got[i] !== ((i == 1) ? s : (i == 23) ? (8'hA5 ^ s) : BASIC[i])) bad++;
      if (p == 0 || p == 255 || p == 256) begin
        checks++; if (bad != 0) begin errors++;
          $display("FAIL wrap_packet%0d got %0d bad bytes want 0", p, bad); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_zero();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_result_tx_packer.md
Name: snn_result_tx_packer

Overview:
- Transmit-side counterpart of the car-datastream receive path. Receive path: UDP bytes → FIFO → pixel SRAM → SNN timesteps → tx trigger.
- On a one-cycle start pulse, this block:
  - reads the output-layer spike counts from the result memory;
  - computes the winning class;
  - serializes a fixed-length result packet, byte by byte, to the UDP TX engine over a valid/ready handshake.
- Runs in the SNN core clock domain, downstream of the per-image timestep controller.

Parameters:
- OUT_NEURON, 10, number of output-layer neurons (classes).
- CNT_W, 16, spike-count width per neuron; fixed at 2 bytes on the wire.
- ADDR_W, 4, result-memory address width; must satisfy 2^ADDR_W >= OUT_NEURON.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- CLK  in  1  core clock.
- RST_N  in  1  asynchronous active-low reset.
- tx_start  in  1  one-cycle pulse: results are valid, send a packet.
- res_addr  out  ADDR_W  result-memory read address.
- res_rd  out  1  result-memory read enable.
- res_rdata  in  CNT_W  spike count; valid exactly 1 cycle after res_rd.
- tx_byte_num  out  16  packet length in bytes; constant 2*OUT_NEURON+4.
- tx_req  out  1  one-cycle pulse to the UDP engine at packet start.
- tx_data  out  8  current packet byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UDP engine accepts a byte when tx_valid && tx_ready.
- busy  out  1  high from accepted tx_start until done.
- done  out  1  one-cycle pulse after the last byte is accepted.
- win_class  out  8  argmax index of the last packet; held.
- drop_cnt  out  8  tx_start pulses ignored while busy; saturates at 255.

Behaviour:
- Reset values: all outputs 0. Internal count registers 0, seq 0, state IDLE.
- Packet layout, in order (24 bytes at defaults):
  - HEADER;
  - seq;
  - count[0]..count[N-1], each MSB byte first;
  - win_class;
  - checksum.
- checksum = XOR of all preceding bytes of the packet.
- State IDLE:
  - tx_start=1 → FETCH; busy=1 from the next cycle.
  - No other activity.
- State FETCH:
  - res_rd=1 with res_addr = 0..N-1 on consecutive cycles.
  - res_rdata captured one cycle later into count[addr-1].
  - Takes N+1 cycles in total.
  - Argmax is updated on each capture with strict greater-than, so ties resolve to the lowest index. All-zero counts give class 0.
  - After the last capture: latch win_class, pulse tx_req with tx_byte_num stable, go to SEND.
- State SEND:
  - Byte index idx runs 0..2N+3; tx_valid=1 and tx_data = byte[idx].
  - tx_data and tx_valid must stay stable while tx_ready=0.
  - On each accept: idx++ and checksum accumulator ^= tx_data.
  - On accepting idx=2N+3: tx_valid=0 in the next cycle, go to DONE.
  - tx_valid may assert in the same cycle as tx_req or later; the first byte is never dropped.
- State DONE:
  - Pulse done for 1 cycle, seq++ (8-bit, wraps 255→0), busy=0, return to IDLE.
- tx_start while busy (FETCH/SEND/DONE):
  - Ignored; the packet in flight is unaffected.
  - drop_cnt++, saturating at 255.
- tx_start in the same cycle as the DONE→IDLE transition counts as busy and is dropped.
- tx_ready held low indefinitely: block waits in SEND with no timeout.
- RST_N low mid-packet:
  - Immediate return to IDLE; tx_valid/tx_req/busy drop asynchronously.
  - seq and drop_cnt clear.
  - No partial-packet completion after reset release.
- Counts are byte-split exactly: high byte = count[15:8], low byte = count[7:0]. Values are not saturated or scaled.
- Latency, with tx_ready held high: tx_start → first accepted byte ≤ N+3 cycles; one byte per cycle thereafter.

Test Plan:
- Basic packet:
  - Stimulus: counts = {3,0,7,1,0,0,2,0,0,5}, tx_ready=1, one tx_start.
  - Required: 24 bytes A5,00,00,03,00,00,00,07,00,01,…,00,05,02,chk, where chk is the XOR of the first 23 bytes; win_class=2; done pulses once; busy drops on the following cycle.
- Tie and zero cases:
  - Stimulus: counts[4]=counts[8]=0x0123, rest 0.
  - Required: win_class=4, and the bytes 01,23 appear at positions 10–11 and 18–19.
  - Stimulus: all counts 0.
  - Required: win_class=0 and chk=A5^seq.
- Backpressure:
  - Stimulus: toggle tx_ready pseudo-randomly at 30% high.
  - Required: the byte sequence is identical to the tx_ready=1 run; tx_data is never changed while tx_valid && !tx_ready.
- Dropped start:
  - Stimulus: 3 tx_start pulses during SEND, then 300 more across later busy windows.
  - Required: drop_cnt reads 3, then saturates at 255; in-flight packet contents are unchanged.
- Sequence wrap:
  - Stimulus: send 257 packets.
  - Required: seq bytes run 00..FF then 00; packet 257 has seq=00.
- Reset mid-operation:
  - Stimulus: assert RST_N low at byte 10 of a packet, then release and send another packet.
  - Required: tx_valid=0 and busy=0 immediately; the next packet has seq=00 and is complete and correct.
